// File: rtl/reg_dump_pkg.sv
// Shared types and default sizing for the register dump block.
// REG_DUMP_CSUM_EN adds the CSUM state used to send a trailing XOR checksum word.
package reg_dump_pkg;

    localparam int DEFAULT_W = 8;
    localparam int DEFAULT_D = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd3
`ifdef REG_DUMP_CSUM_EN
        ,
        CSUM  = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/reg_dump.sv
// Walks every register of a combinational read port and streams each word out over a valid/ready handshake.
// Defining REG_DUMP_CSUM_EN appends an XOR checksum word with OutAddr all ones.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int D = DEFAULT_D
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         Start,
    output logic [D-1:0] RdAddr,
    input  logic [W-1:0] RdData,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] OutData,
    output logic [D-1:0] OutAddr,
    output logic         OutLast,
    output logic         Busy,
    output logic         Done
);

    localparam logic [D-1:0] LAST_IDX = '1;

    state_t       state;
    logic [D-1:0] index;
    logic [W-1:0] data_reg;
`ifdef REG_DUMP_CSUM_EN
    logic [W-1:0] csum;
`endif

    // Each word costs one FETCH cycle to capture the read port, then SEND until it is accepted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            index    <= '0;
            data_reg <= '0;
`ifdef REG_DUMP_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        index <= '0;
`ifdef REG_DUMP_CSUM_EN
                        csum  <= '0;
`endif
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    data_reg <= RdData;
`ifdef REG_DUMP_CSUM_EN
                    csum     <= csum ^ RdData;
`endif
                    state    <= SEND;
                end
                SEND: begin
                    if (OutReady) begin
                        if (index == LAST_IDX) begin
`ifdef REG_DUMP_CSUM_EN
                            state <= CSUM;
`else
                            state <= DONE;
`endif
                        end else begin
                            index <= index + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
`ifdef REG_DUMP_CSUM_EN
                CSUM: begin
                    if (OutReady) begin
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign RdAddr = (state == FETCH) ? index : '0;
    assign Busy   = (state != IDLE);
    assign Done   = (state == DONE);

`ifdef REG_DUMP_CSUM_EN
    assign OutValid = (state == SEND) || (state == CSUM);
    assign OutData  = (state == CSUM) ? csum : data_reg;
    assign OutAddr  = (state == CSUM) ? LAST_IDX : index;
    assign OutLast  = (state == CSUM);
`else
    assign OutValid = (state == SEND);
    assign OutData  = data_reg;
    assign OutAddr  = index;
    assign OutLast  = (state == SEND) && (index == LAST_IDX);
`endif

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump (W=8, D=4); expected words come from a vector table queued on Start.
// Build with REG_DUMP_CSUM_EN to expect the trailing checksum word.
module tb_reg_dump;

`ifdef REG_DUMP_CSUM_EN
    localparam int NWORDS = 17;
`else
    localparam int NWORDS = 16;
`endif

    typedef struct {
        logic [7:0] reg_value;
        logic [7:0] data;
        logic [3:0] addr;
        logic       last;
        int         gap;
    } vec_t;

    logic       CLK;
    logic       RST_N;
    logic       Start;
    logic [3:0] RdAddr;
    logic [7:0] RdData;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] OutData;
    logic [3:0] OutAddr;
    logic       OutLast;
    logic       Busy;
    logic       Done;

    vec_t vec[17];
    vec_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   done_count   = 0;

    reg_dump #(.W(8), .D(4)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Start    (Start),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutAddr  (OutAddr),
        .OutLast  (OutLast),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb RdData = vec[RdAddr].reg_value;

    always @(negedge CLK) if (Done === 1'b1) done_count++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic flag_timeout(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: timed out waiting for OutValid at %0t", name, $time);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_valid"}, OutValid, 0);
        check_output({tag, "_data"},  OutData,  0);
        check_output({tag, "_addr"},  OutAddr,  0);
        check_output({tag, "_last"},  OutLast,  0);
        check_output({tag, "_busy"},  Busy,     0);
        check_output({tag, "_done"},  Done,     0);
        check_output({tag, "_rdaddr"}, RdAddr,  0);
    endtask

    // Drives one dump; optional stall, ignored re-Start, or mid-dump reset at the given word index.
    task automatic apply_stimulus(input int stall_word, input int stall_cycles,
                                  input int restart_word, input int abort_word);
        int         n;
        int         done_base;
        logic [3:0] last_rd;
        vec_t       exp_word;

        for (int i = 0; i < NWORDS; i++) exp_q.push_back(vec[i]);
        done_base = done_count;
        OutReady  = 1'b1;
        Start     = 1'b1;

        for (int i = 0; i < NWORDS; i++) begin
            n       = 0;
            last_rd = '0;
            do begin
                @(negedge CLK);
                n++;
                Start = 1'b0;
                if (!OutValid) last_rd = RdAddr;
            end while (!OutValid && n < 8);

            if (!OutValid) begin
                flag_timeout($sformatf("word%0d_wait", i));
                exp_q.delete();
                return;
            end

            exp_word = exp_q.pop_front();
            check_output($sformatf("word%0d_gap", i),  n,       exp_word.gap);
            if (i < 16) check_output($sformatf("word%0d_rdaddr", i), last_rd, i);
            check_output($sformatf("word%0d_data", i), OutData, exp_word.data);
            check_output($sformatf("word%0d_addr", i), OutAddr, exp_word.addr);
            check_output($sformatf("word%0d_last", i), OutLast, exp_word.last);
            check_output($sformatf("word%0d_busy", i), Busy,    1);

            if (i == abort_word) begin
                RST_N = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge CLK);
                RST_N = 1'b1;
                exp_q.delete();
                @(negedge CLK);
                check_all_zero("post_abort");
                return;
            end

            if (i == stall_word) begin
                OutReady = 1'b0;
                repeat (stall_cycles) begin
                    @(negedge CLK);
                    check_output("stall_valid",  OutValid, 1);
                    check_output("stall_data",   OutData,  exp_word.data);
                    check_output("stall_addr",   OutAddr,  exp_word.addr);
                    check_output("stall_rdaddr", RdAddr,   0);
                end
                OutReady = 1'b1;
            end

            if (i == restart_word) Start = 1'b1;
        end

        @(negedge CLK);
        check_output("done_pulse", Done,     1);
        check_output("done_valid", OutValid, 0);
        check_output("done_busy",  Busy,     1);
        @(negedge CLK);
        check_output("idle_done",  Done, 0);
        check_output("idle_busy",  Busy, 0);
        repeat (3) @(negedge CLK);
        #1;
        check_output("done_count", done_count - done_base, 1);
    endtask

    initial begin
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 16; i++) begin
            vec[i].reg_value = (i < 15) ? 8'(8'h10 + i) : 8'h00;
            vec[i].data      = (i < 15) ? 8'(8'h10 + i) : 8'h00;
            vec[i].addr      = 4'(i);
            vec[i].last      = (NWORDS == 16) && (i == 15);
            vec[i].gap       = 2;
            x                = x ^ vec[i].reg_value;
        end
        vec[16].reg_value = 8'h00;
        vec[16].data      = x;
        vec[16].addr      = 4'hF;
        vec[16].last      = 1'b1;
        vec[16].gap       = 1;

        RST_N    = 1'b0;
        Start    = 1'b0;
        OutReady = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check_all_zero("idle");

        $display("[TB] scenario 1: full dump, sink always ready");
        apply_stimulus(-1, 0, -1, -1);
        $display("[TB] scenario 2: sink stalls 5 cycles on word 3");
        apply_stimulus(3, 5, -1, -1);
        $display("[TB] scenario 3: Start pulsed during word 5");
        apply_stimulus(-1, 0, 5, -1);
        $display("[TB] scenario 4: reset during word 7, then restart");
        apply_stimulus(-1, 0, -1, 7);
        apply_stimulus(-1, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, compared %0d", n_compared);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning register data width in bits.
REQ-002 The block SHALL have parameter D, default 4, meaning register address width; the block dumps 2**D registers.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Start, input, 1 bit: request to begin a dump; sampled only in IDLE.
REQ-006 The block SHALL have port RdAddr, output, D bits: address driven to a combinational register-file read port.
REQ-007 The block SHALL have port RdData, input, W bits: read-port data, valid in the same cycle as RdAddr.
REQ-008 The block SHALL have port OutValid, output, 1 bit: OutData, OutAddr and OutLast are valid.
REQ-009 The block SHALL have port OutReady, input, 1 bit: the sink accepts the word; a handshake is OutValid && OutReady on a rising edge.
REQ-010 The block SHALL have port OutData, output, W bits: the dumped word.
REQ-011 The block SHALL have port OutAddr, output, D bits: the register index of OutData.
REQ-012 The block SHALL have port OutLast, output, 1 bit: the current word is the final word of the dump.
REQ-013 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port Done, output, 1 bit: one-cycle pulse after the final handshake.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, SEND, CSUM and DONE.
REQ-016 In IDLE with Start=1, the block SHALL clear the index to 0 and go to FETCH; Start in any other state SHALL be ignored.
REQ-017 In FETCH, the block SHALL drive RdAddr = index, register RdData into the data register, and go to SEND.
REQ-018 In SEND, OutValid SHALL be 1, and OutData, OutAddr and OutLast SHALL stay stable until the handshake.
REQ-019 On a SEND handshake with index < 2**D-1, the block SHALL increment the index and go to FETCH.
REQ-020 On a SEND handshake with index = 2**D-1, the block SHALL go to CSUM if the checksum feature is enabled, else to DONE.
REQ-021 The first OutValid SHALL occur 2 cycles after Start is sampled; a dump with OutReady held at 1 SHALL take 2 cycles per word.
REQ-022 DONE SHALL assert Done for exactly one cycle and then return to IDLE.
REQ-023 The index SHALL never wrap; it stops at 2**D-1.
REQ-024 RdAddr SHALL be 0 outside FETCH, and OutValid SHALL be 0 outside SEND and CSUM.
REQ-025 The block SHALL pass register data through unmodified, including a hardwired-zero register that reads 0.

Reset
REQ-026 RST_N low SHALL immediately force IDLE, index=0, data=0, checksum=0, and all outputs 0, including mid-dump.
REQ-027 After reset is released, the next Start SHALL restart the dump at register 0.

Configuration
REQ-028 With macro REG_DUMP_CSUM_EN defined, the block SHALL accumulate the XOR of all 2**D words and send it in CSUM with OutAddr = all ones and OutLast=1, then go to DONE.
REQ-029 Without REG_DUMP_CSUM_EN, the CSUM state and accumulator SHALL be absent, and OutLast SHALL be 1 on the word for register 2**D-1.

Structure
REQ-030 A shared package reg_dump_pkg SHALL hold the FSM state enum and the default W and D constants.
REQ-031 The block SHALL be a single module with no sub-module; the checksum is an inline accumulator.

Verification
REQ-032 Scenario 1 (W=8, D=4; reg i = 0x10+i for i<15, reg 15 reads 0; OutReady=1; Start pulse): the bench SHALL see 16 words 0x10..0x1E,0x00 with OutAddr 0..15, first OutValid 2 cycles after Start, and Done once.
REQ-033 Scenario 2 (OutReady=0 for 5 cycles while word 3 is valid): the bench SHALL see OutData=0x13 and OutAddr=3 held stable, with no RdAddr advance.
REQ-034 Scenario 3 (Start pulsed during word 5): the bench SHALL see the sequence unchanged and exactly one Done.
REQ-035 Scenario 4 (RST_N low during word 7): the bench SHALL see all outputs 0 at once, and after release a new Start SHALL give OutAddr 0 first.
REQ-036 Scenario 5 (REG_DUMP_CSUM_EN defined): the bench SHALL see a 17th word 0x1F with OutAddr=0xF and OutLast=1; without the macro, OutLast SHALL be 1 on word 16 (OutData 0x00).
